// File: rtl/demux_skid.sv
// demux_skid: registered 1-to-2 demultiplexer with a small FIFO per output.
// Each input word is steered by in_sel to lane A (0) or lane B (1) and is
// queued there, so back-pressure on one lane never stalls the other.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_data/in_sel          input word and its destination lane
//   in_valid/in_ready       input handshake
//   a_data/a_valid/a_ready  lane A head word and handshake
//   b_data/b_valid/b_ready  lane B head word and handshake
//   a_count/b_count         lane occupancy, 0..DEPTH
module demux_skid #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         a_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         b_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Lane index 0 is A, 1 is B.
  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [WIDTH-1:0] mem_d    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    cnt_q    [2];
  logic [CW-1:0]    cnt_d    [2];

  logic [1:0]       lane_ready;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [CW-1:0]    sel_cnt;

  always_comb begin
    lane_ready = {b_ready, a_ready};
    sel_cnt    = cnt_q[in_sel];
    // A full lane can still accept when its head leaves in the same cycle.
    in_ready   = (sel_cnt < FULL) || lane_ready[in_sel];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = '0;
    pop      = '0;

    for (int i = 0; i < 2; i++) begin
      push[i] = in_valid && in_ready && (in_sel == 1'(i));
      pop[i]  = (cnt_q[i] != '0) && lane_ready[i];

      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data;
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end

      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a_data  = mem_q[0][rd_ptr_q[0]];
  assign b_data  = mem_q[1][rd_ptr_q[1]];
  assign a_valid = (cnt_q[0] != '0);
  assign b_valid = (cnt_q[1] != '0);
  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];

endmodule

// File: tb/tb_demux_skid.sv
module tb_demux_skid;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per lane.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  demux_skid #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  // Drives one cycle from a negedge, advances the model at the posedge and
  // returns at the next negedge. Reports the DUT's in_ready seen before the
  // edge and the model's expectation for it.
  task automatic cyc(input logic v, input logic s, input logic [WIDTH-1:0] d,
                     input logic ar, input logic br,
                     output logic dut_rdy, output logic exp_rdy);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
    exp_rdy = s ? ((qb.size() < DEPTH) || br) : ((qa.size() < DEPTH) || ar);
    dut_rdy = in_ready;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ar && qa.size() > 0) void'(qa.pop_front());
      if (br && qb.size() > 0) void'(qb.pop_front());
      if (v && exp_rdy) begin
        if (s) qb.push_back(d);
        else   qa.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic r, e;
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, r, e);
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, r, e);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    #1;
    total++;
    if ({a_valid, b_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_valid got=%b exp=00", {a_valid, b_valid});
    end
    total++;
    if (a_count !== '0 || b_count !== '0) begin
      bad++; $display("FAIL reset_count got=%0d/%0d exp=0/0", a_count, b_count);
    end
    total++;
    if (a_data !== '0 || b_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", a_data, b_data);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_steering();
    logic r, e;
    cyc(1'b1, 1'b0, 32'h11, 1'b1, 1'b1, r, e);
    total++;
    if (!a_valid || a_data !== 32'h11 || b_valid !== 1'b0) begin
      bad++; $display("FAIL steer_first got=%b/%h/%b exp=1/11/0", a_valid, a_data, b_valid);
    end
    cyc(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, r, e);
    total++;
    if (!b_valid || b_data !== 32'h22 || a_valid !== 1'b0) begin
      bad++; $display("FAIL steer_second got=%b/%h/%b exp=1/22/0", b_valid, b_data, a_valid);
    end
    cyc(1'b1, 1'b0, 32'h33, 1'b1, 1'b1, r, e);
    total++;
    if (!a_valid || a_data !== 32'h33 || b_valid !== 1'b0) begin
      bad++; $display("FAIL steer_third got=%b/%h/%b exp=1/33/0", a_valid, a_data, b_valid);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, r, e);
    total++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      bad++; $display("FAIL steer_drain got=%b/%b exp=0/0", a_valid, b_valid);
    end
  endtask

  task automatic test_full_lane();
    logic r, e;
    cyc(1'b1, 1'b0, 32'd1, 1'b0, 1'b0, r, e);
    cyc(1'b1, 1'b0, 32'd2, 1'b0, 1'b0, r, e);
    total++;
    if (a_count !== CW'(2)) begin
      bad++; $display("FAIL full_count got=%0d exp=2", a_count);
    end
    cyc(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, r, e);
    total++;
    if (r !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL full_in_ready got=%b exp=0 (model %b)", r, e);
    end
    total++;
    if (a_count !== CW'(2) || a_data !== 32'd1) begin
      bad++; $display("FAIL full_hold got=%0d/%h exp=2/1", a_count, a_data);
    end
    cyc(1'b1, 1'b1, 32'd3, 1'b0, 1'b0, r, e);
    total++;
    if (r !== 1'b1 || b_count !== CW'(1) || b_data !== 32'd3) begin
      bad++; $display("FAIL full_other_lane got=%b/%0d/%h exp=1/1/3", r, b_count, b_data);
    end
  endtask

  task automatic test_push_pop_full();
    logic r, e;
    cyc(1'b1, 1'b0, 32'd3, 1'b1, 1'b0, r, e);
    total++;
    if (r !== 1'b1 || a_count !== CW'(2) || a_data !== 32'd2) begin
      bad++; $display("FAIL pp_full got=%b/%0d/%h exp=1/2/2", r, a_count, a_data);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, r, e);
    total++;
    if (a_data !== 32'd3 || a_count !== CW'(1) || b_valid !== 1'b0) begin
      bad++; $display("FAIL pp_pop2 got=%h/%0d/%b exp=3/1/0", a_data, a_count, b_valid);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, r, e);
    total++;
    if (a_valid !== 1'b0 || a_count !== '0) begin
      bad++; $display("FAIL pp_empty got=%b/%0d exp=0/0", a_valid, a_count);
    end
  endtask

  task automatic test_wrap();
    logic r, e;
    logic [WIDTH-1:0] w;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      cyc(1'b1, 1'b1, w, 1'b0, 1'b1, r, e);
      total++;
      if (r !== 1'b1 || b_count !== CW'(1) || b_data !== w) begin
        bad++; $display("FAIL wrap_%0d got=%b/%0d/%h exp=1/1/%h", i, r, b_count, b_data, w);
      end
    end
    cyc(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, r, e);
    total++;
    if (b_count !== '0 || b_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_drain got=%0d/%b exp=0/0", b_count, b_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic r, e;
    cyc(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, r, e);
    cyc(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, r, e);
    cyc(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0, r, e);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, r, e);
    rst_n = 1'b1;
    #1;
    total++;
    if (a_count !== '0 || b_count !== '0 || a_valid || b_valid) begin
      bad++; $display("FAIL midrst_clear got=%0d/%0d exp=0/0", a_count, b_count);
    end
    @(negedge clk);
    cyc(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, r, e);
    total++;
    if (a_data !== 32'h55 || a_count !== CW'(1)) begin
      bad++; $display("FAIL midrst_first got=%h/%0d exp=55/1", a_data, a_count);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, r, e);
  endtask

  task automatic test_random();
    logic r, e, v, s, ar, br;
    logic [WIDTH-1:0] d;
    int pa, pb;
    for (int ph = 0; ph < 6; ph++) begin
      pa = $urandom_range(10, 90);
      pb = $urandom_range(10, 90);
      for (int n = 0; n < 80; n++) begin
        v  = ($urandom_range(0, 99) < 75);
        s  = $urandom;
        d  = $urandom;
        ar = ($urandom_range(0, 99) < pa);
        br = ($urandom_range(0, 99) < pb);
        cyc(v, s, d, ar, br, r, e);
        total++;
        if (r !== e) begin
          bad++; $display("FAIL rnd_in_ready ph%0d c%0d got=%b exp=%b", ph, n, r, e);
        end
        total++;
        if (a_count !== CW'(qa.size()) || b_count !== CW'(qb.size()) ||
            a_valid !== (qa.size() != 0) || b_valid !== (qb.size() != 0)) begin
          bad++; $display("FAIL rnd_count ph%0d c%0d got=%0d/%0d exp=%0d/%0d",
                          ph, n, a_count, b_count, qa.size(), qb.size());
        end
        if (qa.size() != 0) begin
          total++;
          if (a_data !== qa[0]) begin
            bad++; $display("FAIL rnd_a_data ph%0d c%0d got=%h exp=%h", ph, n, a_data, qa[0]);
          end
        end
        if (qb.size() != 0) begin
          total++;
          if (b_data !== qb[0]) begin
            bad++; $display("FAIL rnd_b_data ph%0d c%0d got=%h exp=%h", ph, n, b_data, qb[0]);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_steering();
    test_full_lane();
    test_push_pop_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
